aes_inv_cipher: RTL and testbench

- Iterative AES inverse cipher (FIPS-197 §5.3). Decrypts one 128-bit block using the same expanded key schedule the forward cipher consumes.
- One transformation stage per clock; shares the key-expansion output bus with the encryption path.
- Sits beside the forward cipher in the AES top and implements its decryption direction.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_inv_sbox.sv | 32 +++
 rtl/aes_inv_cipher.sv | 126 ++++++++++++
 tb/tb_aes_inv_cipher.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse cipher.
package aes_pkg;

    // Widest expanded-key bus (Nr=14); narrower buses are zero-extended into it.
    localparam int unsigned KEY_BUS_W = 15 * 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISHIFT = 3'd1,
        ISUB   = 3'd2,
        ADDKEY = 3'd3,
        IMIX   = 3'd4
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Byte i of the state sits at bits 127-8i; row = i%4, column = i/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // Round key r of an Nr-round schedule; round 0 occupies the MSBs of the live bus.
    function automatic logic [127:0] round_key(input logic [KEY_BUS_W-1:0] w,
                                               input int unsigned nr,
                                               input int unsigned r);
        return w[(nr + 1)*128 - 1 - r*128 -: 128];
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module aes_inv_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Entry 0 at the MSBs; 16 entries per row.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // (255 - byte_i) * 8 is the bit offset of the selected entry.
    always_comb begin
        byte_o = INV_SBOX[{~byte_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one transformation stage per clock.
// Define AES_INV_MERGE_SHIFT_SUB_EN to fold InvShiftRows and InvSubBytes into one stage.
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [127:0]           data_in,
    input  logic [(Nr+1)*128-1:0]  w,
    input  logic                   en,
    output logic                   busy,
    output logic                   done,
    output logic [127:0]           data_out
);

    localparam int RW = $clog2(Nr + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(Nr - 1);

    if (Nr != Nk + 6) begin : g_cfg_err
        $error("aes_inv_cipher: Nr must equal Nk+6");
    end

    state_t          state_q, state_d;
    logic [RW-1:0]   round_q, round_d;
    logic [127:0]    blk_q, blk_d;
    logic [127:0]    dout_q, dout_d;
    logic            done_q, done_d;

    logic [KEY_BUS_W-1:0] w_ext;
    logic [127:0]         rk_cur;
    logic [127:0]         sub_in;
    logic [127:0]         sub_out;

    always_comb begin
        w_ext = '0;
        w_ext[(Nr+1)*128-1:0] = w;
    end

    assign rk_cur = round_key(w_ext, Nr, 32'(round_q));

`ifdef AES_INV_MERGE_SHIFT_SUB_EN
    assign sub_in = inv_shift_rows(blk_q);
`else
    assign sub_in = blk_q;
`endif

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .byte_i (sub_in[127 - 8*i -: 8]),
            .byte_o (sub_out[127 - 8*i -: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    blk_d   = data_in ^ round_key(w_ext, Nr, Nr);
                    round_d = LAST_ROUND;
                    state_d = ISHIFT;
                end
            end
            ISHIFT: begin
`ifdef AES_INV_MERGE_SHIFT_SUB_EN
                blk_d   = sub_out;
                state_d = ADDKEY;
`else
                blk_d   = inv_shift_rows(blk_q);
                state_d = ISUB;
`endif
            end
            ISUB: begin
                blk_d   = sub_out;
                state_d = ADDKEY;
            end
            ADDKEY: begin
                blk_d = blk_q ^ rk_cur;
                // Round 0 is the final AddRoundKey; no InvMixColumns follows it.
                if (round_q == '0) begin
                    dout_d  = blk_q ^ rk_cur;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = IMIX;
                end
            end
            IMIX: begin
                blk_d   = inv_mix_columns(blk_q);
                round_d = round_q - 1'b1;
                state_d = ISHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        data_out = dout_q;
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench: FIPS-197 vectors, handshake corner cases, and random blocks
// encrypted by a forward-cipher model and fed to the inverse cipher.
module tb_aes_inv_cipher;

`ifdef AES_INV_MERGE_SHIFT_SUB_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 4;
`endif
    localparam int L10 = STAGES * 10 - 1;
    localparam int L14 = STAGES * 14 - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [127:0]  din10 = '0, din14 = '0;
    logic [1407:0] w10 = '0;
    logic [1919:0] w14 = '0;
    logic          en10 = 1'b0, en14 = 1'b0;
    logic          busy10, busy14, done10, done14;
    logic [127:0]  dout10, dout14;

    int nchecks = 0;
    int nerrors = 0;

    logic [7:0]    sb [256];
    logic [1919:0] wb10;

    always #5 clk = ~clk;

    aes_inv_cipher #(.Nk(4), .Nr(10)) dut10 (
        .clk(clk), .rst(rst), .data_in(din10), .w(w10), .en(en10),
        .busy(busy10), .done(done10), .data_out(dout10)
    );

    aes_inv_cipher #(.Nk(8), .Nr(14)) dut14 (
        .clk(clk), .rst(rst), .data_in(din14), .w(w14), .en(en14),
        .busy(busy14), .done(done14), .data_out(dout14)
    );

    // ---------------- reference model (forward AES) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv, y;
        inv = '0;
        for (int k = 1; k < 256; k++) if (gmul(x, 8'(k)) == 8'h01) inv = 8'(k);
        for (int i = 0; i < 8; i++)
            y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
        return y ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Returns the schedule with word 0 at the MSBs of a 1920-bit bus.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   wd [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] bus;
        int            total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        bus = '0;
        for (int i = 0; i < nk; i++) wd[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            tmp = wd[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            wd[i] = wd[i-nk] ^ tmp;
        end
        for (int i = 0; i < total; i++) bus[1919 - 32*i -: 32] = wd[i];
        return bus;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] wb,
                                             input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] blk;
        blk = pt ^ wb[1919 -: 128];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[blk[127 - 8*i -: 8]];
            for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = t[4*c + j];
                    for (int j = 0; j < 4; j++)
                        t[4*c + j] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03)
                                   ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = t[i];
            blk = blk ^ wb[1919 - 128*r -: 128];
        end
        return blk;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking / driving helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Returns at the negedge following the acceptance edge.
    task automatic start(input bit big, input logic [127:0] ct);
        @(negedge clk);
        if (big) begin din14 = ct; en14 = 1'b1; end
        else     begin din10 = ct; en10 = 1'b1; end
        @(negedge clk);
        en10 = 1'b0;
        en14 = 1'b0;
        din10 = ~din10;
        din14 = ~din14;
    endtask

    task automatic wait_done(input bit big, input int limit, output int n);
        n = 0;
        while (!(big ? done14 : done10) && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_block(input bit big, input logic [127:0] ct, input logic [127:0] exp,
                             input string nm);
        int n;
        int lat;
        lat = big ? L14 : L10;
        start(big, ct);
        chk({nm, "_busy"}, 128'(big ? busy14 : busy10), 128'(1));
        wait_done(big, lat + 20, n);
        chk({nm, "_latency"}, 128'(n), 128'(lat));
        chk({nm, "_data"}, big ? dout14 : dout10, exp);
        @(negedge clk);
        chk({nm, "_done_pulse"}, 128'(big ? done14 : done10), 128'(0));
        chk({nm, "_idle"}, 128'(big ? busy14 : busy10), 128'(0));
        chk({nm, "_hold"}, big ? dout14 : dout10, exp);
    endtask

    typedef struct {
        logic [255:0] key;
        int           nk;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [2];

    initial begin
        int n, n2, pulses, first;
        logic [127:0] pta, ptb, cta, ctb, cap;
        logic [1919:0] wb;

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

        vecs[0] = '{key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, nk: 4,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt: 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    nk: 8, ct: 128'h8ea2b7ca516745bfeafc49904b496089,
                    pt: 128'h00112233445566778899aabbccddeeff};

        // Reset state
        rst = 1'b1;
        din10 = rnd128();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy10", 128'(busy10), 128'(0));
        chk("rst_done10", 128'(done10), 128'(0));
        chk("rst_dout10", dout10, 128'h0);
        chk("rst_busy14", 128'(busy14), 128'(0));
        chk("rst_dout14", dout14, 128'h0);

        // FIPS-197 vectors
        for (int v = 0; v < 2; v++) begin
            wb = expand(vecs[v].key, vecs[v].nk);
            chk($sformatf("model_v%0d", v), encrypt(vecs[v].pt, wb, vecs[v].nk + 6), vecs[v].ct);
            if (vecs[v].nk == 4) begin
                wb10 = wb;
                w10 = wb[1919 -: 1408];
            end else begin
                w14 = wb;
            end
            run_block(vecs[v].nk == 8, vecs[v].ct, vecs[v].pt, $sformatf("fips_v%0d", v));
        end

        // Back-to-back: en asserted in the done cycle
        pta = vecs[0].pt;
        cta = vecs[0].ct;
        ptb = rnd128();
        ctb = encrypt(ptb, wb10, 10);
        start(1'b0, cta);
        wait_done(1'b0, L10 + 20, n);
        chk("b2b_first_latency", 128'(n), 128'(L10));
        chk("b2b_first_data", dout10, pta);
        din10 = ctb;
        en10 = 1'b1;
        @(negedge clk);
        en10 = 1'b0;
        chk("b2b_done_low", 128'(done10), 128'(0));
        chk("b2b_busy", 128'(busy10), 128'(1));
        wait_done(1'b0, L10 + 20, n2);
        chk("b2b_interval", 128'(n2 + 1), 128'(L10 + 1));
        chk("b2b_second_data", dout10, ptb);

        // en while busy is ignored
        pta = rnd128();
        cta = encrypt(pta, wb10, 10);
        start(1'b0, cta);
        pulses = 0;
        first = -1;
        cap = '0;
        for (int k = 0; k < L10 + 30; k++) begin
            en10 = (k == 9);
            if (k == 9) din10 = rnd128();
            @(negedge clk);
            if (done10) begin
                pulses++;
                if (first < 0) begin first = k + 1; cap = dout10; end
            end
        end
        en10 = 1'b0;
        chk("busy_en_pulses", 128'(pulses), 128'(1));
        chk("busy_en_latency", 128'(first), 128'(L10));
        chk("busy_en_data", cap, pta);

        // Reset mid-block
        start(1'b0, cta);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 128'(busy10), 128'(0));
        chk("midrst_done", 128'(done10), 128'(0));
        chk("midrst_dout", dout10, 128'h0);
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done10) pulses++;
        end
        chk("midrst_no_done", 128'(pulses), 128'(0));
        run_block(1'b0, cta, pta, "midrst_fresh");

        // Random keys and plaintexts against the forward model
        for (int r = 0; r < 4; r++) begin
            wb10 = expand({rnd128(), 128'h0}, 4);
            w10 = wb10[1919 -: 1408];
            pta = rnd128();
            run_block(1'b0, encrypt(pta, wb10, 10), pta, $sformatf("rnd10_%0d", r));
        end
        for (int r = 0; r < 2; r++) begin
            wb = expand({rnd128(), rnd128()}, 8);
            w14 = wb;
            pta = rnd128();
            run_block(1'b1, encrypt(pta, wb, 14), pta, $sformatf("rnd14_%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
